// File: rtl/axis_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_pkg
// Description : Shared AXI-Stream definitions: RAM word layout, frame status
//               encodings and pointer sizing helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_pkg;

  // Word layout {tlast, tkeep, tdata} for the default 8-bit narrow side
  localparam int AXIS_NARROW_DW = 8;
  localparam int KEEP_LSB       = AXIS_NARROW_DW;
  localparam int TLAST_BIT      = KEEP_LSB + AXIS_NARROW_DW / 8;

  typedef enum logic [1:0] {
    FRAME_NONE     = 2'd0,
    FRAME_GOOD     = 2'd1,
    FRAME_BAD      = 2'd2,
    FRAME_OVERFLOW = 2'd3
  } frame_status_e;

  // One extra bit distinguishes full from empty when addresses alias
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic int keep_lsb(input int data_width);
    return data_width;
  endfunction

  function automatic int tlast_bit(input int data_width, input int keep_width);
    return data_width + keep_width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : axis_fifo_ram
// Description : Simple dual-port RAM, one write port and one registered
//               (synchronous) read port.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_fifo_ram #(
  parameter int ADDR_WIDTH = 12,
  parameter int WORD_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [WORD_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [WORD_WIDTH-1:0] o_rd_data
);

  logic [WORD_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [WORD_WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read register doubles as the FIFO output register, so it clears on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/axis_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module      : axis_frame_fifo
// Description : Store-and-forward AXI-Stream frame FIFO; releases only whole
//               frames whose last beat has tuser=0. Define
//               AXIS_FIFO_DROP_WHEN_FULL_EN to drop frames instead of stalling.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_frame_fifo
  import axis_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] input_axis_tkeep,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  input  logic                  input_axis_tlast,
  input  logic                  input_axis_tuser,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic [KEEP_WIDTH-1:0] output_axis_tkeep,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  output logic                  output_axis_tlast,
  output logic                  overflow,
  output logic                  bad_frame,
  output logic                  good_frame
);

  localparam int c_pw        = ptr_width(ADDR_WIDTH);
  localparam int c_keep_lsb  = keep_lsb(DATA_WIDTH);
  localparam int c_tlast_bit = tlast_bit(DATA_WIDTH, KEEP_WIDTH);
  localparam int c_word_w    = c_tlast_bit + 1;
  localparam logic [c_pw-1:0] c_depth   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [c_pw-1:0] c_ptr_one = {{(c_pw-1){1'b0}}, 1'b1};

  logic [c_pw-1:0]   r_wr_ptr, r_wr_ptr_cur, r_rd_ptr;
  logic [c_pw-1:0]   w_wr_ptr_nxt, w_wr_ptr_cur_nxt;
  logic              r_drop_frame, w_drop_frame_nxt;
  logic              r_in_en;
  logic              r_out_valid;
  frame_status_e     r_status, w_status_nxt;
  logic              w_full, w_full_cur, w_empty;
  logic              w_drop_cond, w_wr_acc, w_wr_en, w_rd_en;
  logic [c_word_w-1:0] w_rd_word;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr_cur[c_pw-1] != r_rd_ptr[c_pw-1]) &&
                      (r_wr_ptr_cur[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);
  assign w_full_cur = ((r_wr_ptr_cur - r_wr_ptr) == c_depth);

`ifdef AXIS_FIFO_DROP_WHEN_FULL_EN
  assign input_axis_tready = r_in_en;
  assign w_drop_cond       = w_full | w_full_cur | r_drop_frame;
`else
  // A frame that alone fills the FIFO must keep flowing so it can be discarded
  assign input_axis_tready = r_in_en & (~w_full | w_full_cur | r_drop_frame);
  assign w_drop_cond       = w_full_cur | r_drop_frame;
`endif

  assign w_wr_acc = input_axis_tvalid & input_axis_tready;
  assign w_wr_en  = w_wr_acc & ~w_drop_cond;

  always_comb begin
    w_wr_ptr_nxt     = r_wr_ptr;
    w_wr_ptr_cur_nxt = r_wr_ptr_cur;
    w_drop_frame_nxt = r_drop_frame;
    w_status_nxt     = FRAME_NONE;
    if (w_wr_acc) begin
      if (w_drop_cond) begin
        w_drop_frame_nxt = 1'b1;
        w_wr_ptr_cur_nxt = r_wr_ptr;
        if (input_axis_tlast) begin
          w_drop_frame_nxt = 1'b0;
          w_status_nxt     = FRAME_OVERFLOW;
        end
      end else begin
        w_wr_ptr_cur_nxt = r_wr_ptr_cur + c_ptr_one;
        if (input_axis_tlast) begin
          if (input_axis_tuser) begin
            w_wr_ptr_cur_nxt = r_wr_ptr;
            w_status_nxt     = FRAME_BAD;
          end else begin
            w_wr_ptr_nxt = r_wr_ptr_cur + c_ptr_one;
            w_status_nxt = FRAME_GOOD;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_wr_ptr_cur <= '0;
      r_drop_frame <= 1'b0;
      r_status     <= FRAME_NONE;
      r_in_en      <= 1'b0;
    end else begin
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_wr_ptr_cur <= w_wr_ptr_cur_nxt;
      r_drop_frame <= w_drop_frame_nxt;
      r_status     <= w_status_nxt;
      r_in_en      <= 1'b1;
    end
  end

  // Only committed beats (below wr_ptr) are visible to the read side
  assign w_rd_en = ~w_empty & (~r_out_valid | output_axis_tready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr    <= '0;
      r_out_valid <= 1'b0;
    end else if (w_rd_en) begin
      r_rd_ptr    <= r_rd_ptr + c_ptr_one;
      r_out_valid <= 1'b1;
    end else if (output_axis_tready) begin
      r_out_valid <= 1'b0;
    end
  end

  axis_fifo_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WORD_WIDTH (c_word_w)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr_cur[ADDR_WIDTH-1:0]),
    .i_wr_data ({input_axis_tlast, input_axis_tkeep, input_axis_tdata}),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_ptr[ADDR_WIDTH-1:0]),
    .o_rd_data (w_rd_word)
  );

  assign output_axis_tdata  = w_rd_word[c_keep_lsb-1:0];
  assign output_axis_tkeep  = w_rd_word[c_tlast_bit-1:c_keep_lsb];
  assign output_axis_tlast  = w_rd_word[c_tlast_bit];
  assign output_axis_tvalid = r_out_valid;

  assign good_frame = (r_status == FRAME_GOOD);
  assign bad_frame  = (r_status == FRAME_BAD);
  assign overflow   = (r_status == FRAME_OVERFLOW);

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_frame_fifo
// Description : Randomised self-checking bench for axis_frame_fifo against a
//               frame-level queue model (depth 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_frame_fifo;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_tdata  = '0;
  logic [0:0] in_tkeep  = '0;
  logic       in_tvalid = 1'b0;
  logic       in_tlast  = 1'b0;
  logic       in_tuser  = 1'b0;
  logic       in_tready;
  logic [7:0] out_tdata;
  logic [0:0] out_tkeep;
  logic       out_tvalid;
  logic       out_tready = 1'b0;
  logic       out_tlast;
  logic       overflow, bad_frame, good_frame;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ready_mode = 0;        // 0: always ready, 1: random 50 %, 2: stalled
  int tlast_acc_cyc = 0;
  int first_valid_cyc = -1;
  int exp_good = 0, exp_bad = 0, exp_ovf = 0;
  int n_good = 0, n_bad = 0, n_ovf = 0;
  logic prev_valid = 1'b0;
  logic [9:0] exp_q[$];      // {tlast, tkeep, tdata} of committed beats
  int hs_cyc[$];

  axis_frame_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(8), .KEEP_WIDTH(1)) dut (
    .clk                (clk),
    .rst                (rst),
    .input_axis_tdata   (in_tdata),
    .input_axis_tkeep   (in_tkeep),
    .input_axis_tvalid  (in_tvalid),
    .input_axis_tready  (in_tready),
    .input_axis_tlast   (in_tlast),
    .input_axis_tuser   (in_tuser),
    .output_axis_tdata  (out_tdata),
    .output_axis_tkeep  (out_tkeep),
    .output_axis_tvalid (out_tvalid),
    .output_axis_tready (out_tready),
    .output_axis_tlast  (out_tlast),
    .overflow           (overflow),
    .bad_frame          (bad_frame),
    .good_frame         (good_frame)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_tready = 1'b1;
      1:       out_tready = 1'($urandom_range(0, 1));
      default: out_tready = 1'b0;
    endcase
  end

  // Output monitor and status pulse counters
  always @(negedge clk) begin
    if (!rst) begin
      if (good_frame) n_good++;
      if (bad_frame)  n_bad++;
      if (overflow)   n_ovf++;
      if (out_tvalid && !prev_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_tvalid && out_tready) begin
        hs_cyc.push_back(cyc);
        check("out_beat_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("out_beat", {out_tlast, out_tkeep, out_tdata}, exp_q.pop_front());
      end
    end
    prev_valid = out_tvalid;
  end

  task automatic send_beat(input logic [7:0] d, input logic k, input logic l, input logic u, input bit gap);
    bit acc = 1'b0;
    int guard = 0;
    if (gap && $urandom_range(0, 3) == 0) begin
      in_tvalid = 1'b0;
      @(posedge clk); #1;
    end
    in_tdata = d; in_tkeep = k; in_tlast = l; in_tuser = u; in_tvalid = 1'b1;
    while (!acc && guard < 2000) begin
      @(negedge clk); acc = in_tready;
      @(posedge clk); #1; guard++;
    end
    if (!acc) check("in_accept_timeout", 32'(acc), 1);
    in_tvalid = 1'b0;
    if (l) tlast_acc_cyc = cyc;
  endtask

  // Model: oversize frames overflow, bad frames vanish, good frames queue up
  task automatic send_frame(input logic [7:0] d[$], input bit bad, input bit gap);
    logic [9:0] w[$];
    logic k, l;
    for (int i = 0; i < d.size(); i++) begin
      k = 1'($urandom);
      l = (i == d.size() - 1);
      send_beat(d[i], k, l, l ? bad : 1'($urandom), gap);
      w.push_back({l, k, d[i]});
    end
    if (d.size() > DEPTH) exp_ovf++;
    else if (bad) exp_bad++;
    else begin
      exp_good++;
      foreach (w[i]) exp_q.push_back(w[i]);
    end
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while ((exp_q.size() != 0 || out_tvalid) && guard < 5000) begin
      @(posedge clk); #1; guard++;
    end
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_good_cnt"}, n_good, exp_good);
    check({tag, "_bad_cnt"}, n_bad, exp_bad);
    check({tag, "_ovf_cnt"}, n_ovf, exp_ovf);
  endtask

  initial begin
    logic [7:0] f[$];
    int guard;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", {in_tready, out_tvalid, out_tlast, out_tdata, good_frame, bad_frame, overflow}, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("ready_after_rst", 32'(in_tready), 1);
    @(posedge clk); #1;

    // Single good frame and its first-beat latency (tvalid seen in the second cycle after the tlast cycle)
    ready_mode = 0;
    first_valid_cyc = -1;
    f = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(f, 1'b0, 1'b0);
    drain("t1");
    check("t1_latency", first_valid_cyc - tlast_acc_cyc, 1);

    // Bad frame followed by a good frame
    f = '{8'h11, 8'h22, 8'h33};
    send_frame(f, 1'b1, 1'b0);
    f = '{8'hAA, 8'hBB};
    send_frame(f, 1'b0, 1'b0);
    drain("t2");

    // Oversize frame, then a short frame must still pass
    f.delete();
    for (int i = 0; i < 20; i++) f.push_back(8'(8'h40 + i));
    send_frame(f, 1'b0, 1'b0);
    f = '{8'hC1, 8'hC2};
    send_frame(f, 1'b0, 1'b0);
    drain("t3");

    // Back-pressure: two 8-byte frames plus one beat fill RAM and output register
    ready_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    for (int n = 0; n < 2; n++) begin
      f.delete();
      for (int i = 0; i < 8; i++) f.push_back(8'($urandom));
      send_frame(f, 1'b0, 1'b0);
    end
    send_beat(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("t4_in_stalled", 32'(in_tready), 0);
    @(posedge clk); #1;
    hs_cyc.delete();
    ready_mode = 0;
    send_beat(8'h66, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_good++;
    exp_q.push_back({1'b0, 1'b1, 8'h55});
    exp_q.push_back({1'b1, 1'b1, 8'h66});
    guard = 0;
    while (hs_cyc.size() < 16 && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    check("t4_burst_len", 32'(hs_cyc.size() >= 16), 1);
    if (hs_cyc.size() >= 16) check("t4_burst_cycles", hs_cyc[15] - hs_cyc[0], 15);
    drain("t4");

    // Random frames with random downstream stalls
    ready_mode = 1;
    for (int n = 0; n < 100; n++) begin
      int len;
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(17, 20) : $urandom_range(1, 16);
      f.delete();
      for (int i = 0; i < len; i++) f.push_back(8'($urandom));
      send_frame(f, ($urandom_range(0, 7) == 0), 1'b1);
    end
    ready_mode = 0;
    drain("t5");

    // Reset in the middle of a frame
    send_beat(8'hE1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_beat(8'hE2, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("t6_valid_after_rst", 32'(out_tvalid), 0);
    @(posedge clk); #1;
    f = '{8'h71, 8'h72, 8'h73};
    send_frame(f, 1'b0, 1'b0);
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
